seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/kgp_alu_pkg.sv | 66 ++++++
 rtl/alu_shifter.sv | 36 +++
 rtl/seq_alu.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/kgp_alu_pkg.sv
// Shared encodings, flag layout and helper functions for the sequential ALU (seq_alu).
// SEQ_ALU_FAST_SHIFT_EN selects the single-cycle barrel shift in the design files.
package kgp_alu_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_COMP  = 3'b011;
    localparam logic [2:0] OP_SHIFT = 3'b100;
    localparam logic [2:0] OP_NOP   = 3'b111;

    localparam logic [2:0] FS_ZERO   = 3'b000;
    localparam logic [2:0] FS_NZERO  = 3'b001;
    localparam logic [2:0] FS_NEG    = 3'b010;
    localparam logic [2:0] FS_CARRY  = 3'b011;
    localparam logic [2:0] FS_ALWAYS = 3'b100;
    localparam logic [2:0] FS_NONE   = 3'b111;

    // flags vector is {carry, zero, sign, overflow}
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                              input logic             c,
                                              input logic             v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_Z] = (r == '0);
        f[FLAG_S] = r[WIDTH-1];
        f[FLAG_V] = v;
        return f;
    endfunction

    // Unlisted condition codes fall through to "never taken".
    function automatic logic branch_eval(input logic [2:0] sel,
                                         input logic [3:0] f);
        logic taken;
        taken = 1'b0;
        case (sel)
            FS_ZERO:   taken = f[FLAG_Z];
            FS_NZERO:  taken = ~f[FLAG_Z];
            FS_NEG:    taken = f[FLAG_S];
            FS_CARRY:  taken = f[FLAG_C];
            FS_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift datapath for seq_alu: a one-bit step by default, or a full barrel shift
// when SEQ_ALU_FAST_SHIFT_EN is defined.
module alu_shifter
    import kgp_alu_pkg::*;
(
    input  logic [WIDTH-1:0]   data,
`ifdef SEQ_ALU_FAST_SHIFT_EN
    input  logic [SHAMT_W-1:0] amount,
`endif
    input  logic               is_log,
    input  logic               dir,
    output logic [WIDTH-1:0]   shifted
);

`ifdef SEQ_ALU_FAST_SHIFT_EN
    // Arithmetic left is the same as logical left, so only the right shift cares about is_log.
    always_comb begin
        if (dir) begin
            shifted = data << amount;
        end else if (is_log) begin
            shifted = data >> amount;
        end else begin
            shifted = $signed(data) >>> amount;
        end
    end
`else
    always_comb begin
        if (dir) begin
            shifted = {data[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {(is_log ? 1'b0 : data[WIDTH-1]), data[WIDTH-1:1]};
        end
    end
`endif

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with registered result/flags and a branch condition evaluated at accept.
// Define SEQ_ALU_FAST_SHIFT_EN to replace the bit-serial shift with a single-cycle barrel shift.
module seq_alu
    import kgp_alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op_switch,
    input  logic [2:0]       flag_switch,
    input  logic             is_log,
    input  logic             dir,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             branch_taken
);

    logic [1:0]       state_q;
    logic             accept;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] comp_val;
    logic [WIDTH-1:0] acc_val;
    logic             acc_c;
    logic             acc_v;
    logic             acc_commit;
    logic [WIDTH-1:0] shift_out;

    assign accept   = start && (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign add_sum  = {1'b0, a} + {1'b0, b};
    assign comp_val = ~b + WIDTH'(1);

`ifdef SEQ_ALU_FAST_SHIFT_EN
    alu_shifter u_shifter (
        .data    (a),
        .amount  (b[SHAMT_W-1:0]),
        .is_log  (is_log),
        .dir     (dir),
        .shifted (shift_out)
    );
`else
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   shreg_q;
    logic               sh_log_q;
    logic               sh_dir_q;
    logic               go_shift;

    // The shift works on a private copy so result keeps its old value until the op finishes.
    alu_shifter u_shifter (
        .data    (shreg_q),
        .is_log  (sh_log_q),
        .dir     (sh_dir_q),
        .shifted (shift_out)
    );
`endif

    // Value and flag inputs to commit when an op finishes straight from IDLE.
    always_comb begin
        acc_val    = '0;
        acc_c      = 1'b0;
        acc_v      = 1'b0;
        acc_commit = 1'b1;
`ifndef SEQ_ALU_FAST_SHIFT_EN
        go_shift   = 1'b0;
`endif
        case (op_switch)
            OP_ADD: begin
                acc_val = add_sum[WIDTH-1:0];
                acc_c   = add_sum[WIDTH];
                acc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: begin
                acc_val = a & b;
            end
            OP_XOR: begin
                acc_val = a ^ b;
            end
            OP_COMP: begin
                acc_val = comp_val;
                acc_c   = (b == '0);
                acc_v   = (b == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_SHIFT: begin
`ifdef SEQ_ALU_FAST_SHIFT_EN
                acc_val = shift_out;
`else
                acc_val  = a;
                go_shift = (b[SHAMT_W-1:0] != '0);
`endif
            end
            default: begin
                acc_commit = 1'b0;
            end
        endcase
    end

    // Branch is judged against the flags left by the previous op, before this one commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            result       <= '0;
            flags        <= '0;
            branch_taken <= 1'b0;
`ifndef SEQ_ALU_FAST_SHIFT_EN
            cnt_q        <= '0;
            shreg_q      <= '0;
            sh_log_q     <= 1'b0;
            sh_dir_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        branch_taken <= branch_eval(flag_switch, flags);
`ifndef SEQ_ALU_FAST_SHIFT_EN
                        if (go_shift) begin
                            state_q  <= ST_SHIFT;
                            cnt_q    <= b[SHAMT_W-1:0];
                            shreg_q  <= a;
                            sh_log_q <= is_log;
                            sh_dir_q <= dir;
                        end else
`endif
                        begin
                            state_q <= ST_DONE;
                            if (acc_commit) begin
                                result <= acc_val;
                                flags  <= pack_flags(acc_val, acc_c, acc_v);
                            end
                        end
                    end
                end
`ifndef SEQ_ALU_FAST_SHIFT_EN
                ST_SHIFT: begin
                    cnt_q   <= cnt_q - SHAMT_W'(1);
                    shreg_q <= shift_out;
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q <= ST_DONE;
                        result  <= shift_out;
                        flags   <= pack_flags(shift_out, 1'b0, 1'b0);
                    end
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
